// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Imported by the arbiter FSM and its watchdog.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] FETCH_SIZE       = 4'd8;
    localparam int         DEFAULT_MAX_WAIT = 15;

    // Pick the 32-bit instruction out of a 64-bit memory word.
    function automatic logic [31:0] word_sel(
        input logic [63:0] d,
        input logic        hi
    );
        return hi ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Wait counter for an in-flight memory access.
// Cleared on access start; flags expiry once MAX_WAIT cycles have elapsed.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one 64-bit memory between IF and MEM.
// Data requests win; every access ends with a one-cycle ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_instr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [3:0]  d_size,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_size,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    output logic        if_stall,
    output logic        d_stall,
    output logic        timeout_err
);

    arb_state_t  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [63:0] d_rdata_q, d_rdata_d;
    logic        timeout_q, timeout_d;

    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;
    logic [63:0] rsp_data;
    port_t       served;

    assign wd_enable = (state_q == DATA) || (state_q == INST);
    assign served    = (state_q == DATA) ? PORT_D : PORT_I;

    arb_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        if_instr_d = if_instr_q;
        d_rdata_d  = d_rdata_q;
        timeout_d  = timeout_q;
        wd_clear   = 1'b0;
        rsp_data   = 64'd0;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = DATA;
                    mem_req_d = 1'b1;
                    we_d      = d_we;
                    addr_d    = d_addr;
                    wdata_d   = d_wdata;
                    size_d    = d_size;
                    wd_clear  = 1'b1;
                end else if (if_req) begin
                    state_d   = INST;
                    mem_req_d = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = if_addr & ~64'h3;
                    wdata_d   = 64'd0;
                    size_d    = FETCH_SIZE;
                    wd_clear  = 1'b1;
                end
            end
            DATA, INST: begin
                // A late mem_ready on the expiry cycle still counts as success.
                if (mem_ready || wd_expired) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    rsp_data  = mem_ready ? mem_rdata : 64'd0;
                    if (!mem_ready) begin
                        timeout_d = 1'b1;
                    end
                    if (served == PORT_D) begin
                        d_ready_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = rsp_data;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_instr_d = word_sel(rsp_data, addr_q[2]);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            size_q     <= 4'd0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_instr_q <= 32'd0;
            d_rdata_q  <= 64'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            if_instr_q <= if_instr_d;
            d_rdata_q  <= d_rdata_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_size    = size_q;
    assign if_ready    = if_ready_q;
    assign d_ready     = d_ready_q;
    assign if_instr    = if_instr_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = timeout_q;

    assign if_stall = if_req & ~if_ready_q;
    assign d_stall  = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random IF/MEM traffic against a
// behavioural memory with programmable response delay and hung accesses.
module tb_mem_arbiter;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_instr;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [3:0]  d_size = 4'd8;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_size;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        if_stall;
    logic        d_stall;
    logic        timeout_err;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_instr(if_instr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_size(d_size),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .d_stall(d_stall),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [63:0] exp;
        int          k;
        bit          hang;
    } rec_t;

    rec_t q_d[$];
    rec_t q_i[$];
    logic [63:0] ref_mem [logic [60:0]];
    logic [63:0] phys_mem [logic [60:0]];
    logic [3:0]  sizes [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

    int checks = 0;
    int errors = 0;
    int last_d_lat = 0;
    int last_i_lat = 0;

    function automatic logic [63:0] init_word(input logic [60:0] w);
        logic [31:0] lo;
        lo = w[31:0];
        return {lo ^ 32'h5A5A_0F0F, ~lo};
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a[63:3]) ? ref_mem[a[63:3]] : init_word(a[63:3]);
    endfunction

    function automatic logic [63:0] phys_rd(input logic [63:0] a);
        return phys_mem.exists(a[63:3]) ? phys_mem[a[63:3]] : init_word(a[63:3]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic data_txn(input bit we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [3:0] size,
                            input int k, input bit hang);
        rec_t r;
        int n;
        r.we = we; r.addr = addr; r.wdata = wdata; r.size = size;
        r.k = k; r.hang = hang; r.exp = '0;
        if (!we && !hang) r.exp = ref_rd(addr);
        if (we && !hang) ref_mem[addr[63:3]] = wdata;
        q_d.push_back(r);
        d_we = we; d_addr = addr; d_wdata = wdata; d_size = size;
        d_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!d_ready && n < 60);
        checks++;
        if (!d_ready) begin
            errors++;
            $display("FAIL d_handshake: no d_ready within %0d cycles, required a pulse", n);
        end
        d_req = 1'b0;
        last_d_lat = n;
    endtask

    task automatic fetch_txn(input logic [63:0] addr, input int k, input bit hang);
        rec_t r;
        int n;
        logic [63:0] w;
        w = ref_rd(addr);
        r.we = 1'b0; r.addr = addr; r.wdata = '0; r.size = 4'd8;
        r.k = k; r.hang = hang;
        r.exp = hang ? 64'd0 : {32'd0, (addr[2] ? w[63:32] : w[31:0])};
        q_i.push_back(r);
        if_addr = addr;
        if_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!if_ready && n < 60);
        checks++;
        if (!if_ready) begin
            errors++;
            $display("FAIL if_handshake: no if_ready within %0d cycles, required a pulse", n);
        end
        if_req = 1'b0;
        last_i_lat = n;
    endtask

    // Monitor plus behavioural memory, evaluated once per cycle.
    int          cyc = 0;
    bit          busy = 0;
    int          done_cyc = -10;
    bit          cur_d = 0;
    rec_t        cur;
    bit          prev_d = 0;
    bit          prev_i = 0;
    bit          te_exp = 0;
    logic [63:0] exp_drdata = '0;
    bit          exp_rise, exp_dr, exp_ir, fin;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            busy = 0; done_cyc = -10; te_exp = 0; exp_drdata = '0;
            mem_ready = 1'b0; prev_d = 0; prev_i = 0;
        end else begin
            exp_rise = !busy && (done_cyc != cyc - 1) && (prev_d || prev_i);
            mem_ready = 1'b0;
            if (busy) chk("mem_req_hold", mem_req, 64'(cyc < done_cyc));
            else chk("mem_req_start", mem_req, 64'(exp_rise));
            if (!busy && exp_rise) begin
                cur_d = prev_d;
                if (cur_d ? (q_d.size() == 0) : (q_i.size() == 0)) begin
                    checks++; errors++;
                    $display("FAIL arb_order: got access with empty queue, required a queued request");
                end else begin
                    cur = cur_d ? q_d[0] : q_i[0];
                    busy = 1;
                    done_cyc = cyc + (cur.hang ? MW + 1 : cur.k + 1);
                end
            end
            if (busy && cyc < done_cyc) begin
                chk("mem_we", mem_we, 64'(cur.we));
                chk("mem_addr", mem_addr, cur.addr & ~64'h3);
                chk("mem_size", mem_size, 64'(cur.size));
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (busy && !cur.hang && cyc == done_cyc - 1) begin
                mem_ready = 1'b1;
                mem_rdata = phys_rd(mem_addr);
                if (mem_we) phys_mem[mem_addr[63:3]] = mem_wdata;
            end else begin
                mem_rdata = {$urandom, $urandom};
            end
            fin = busy && (cyc == done_cyc);
            exp_dr = fin && cur_d;
            exp_ir = fin && !cur_d;
            chk("d_ready", d_ready, 64'(exp_dr));
            chk("if_ready", if_ready, 64'(exp_ir));
            if (fin) begin
                if (cur.hang) te_exp = 1;
                if (cur_d) begin
                    if (!cur.we) exp_drdata = cur.exp;
                    chk("d_rdata", d_rdata, exp_drdata);
                    void'(q_d.pop_front());
                end else begin
                    chk("if_instr", 64'(if_instr), cur.exp);
                    void'(q_i.pop_front());
                end
                busy = 0;
            end
            chk("timeout_err", timeout_err, 64'(te_exp));
            chk("if_stall", if_stall, 64'(if_req && !exp_ir));
            chk("d_stall", d_stall, 64'(d_req && !exp_dr));
            prev_d = d_req;
            prev_i = if_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, required $finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        phys_mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        ref_mem[0]  = 64'hAAAA_BBBB_CCCC_DDDD;
        fetch_txn(64'h4, 0, 0);
        chk("fetch_latency", last_i_lat, 2);
        chk("fetch_word", 64'(if_instr), 64'hAAAA_BBBB);
        repeat (2) @(posedge clk);
        #2;

        fork
            data_txn(1'b0, 64'h10, 64'd0, 4'd8, 2, 0);
            fetch_txn(64'h1000, 2, 0);
        join
        chk("simul_d_latency", last_d_lat, 4);
        chk("simul_i_latency", last_i_lat, 9);
        repeat (2) @(posedge clk);
        #2;

        data_txn(1'b1, 64'h20, 64'h1234, 4'd8, 3, 0);
        chk("store_latency", last_d_lat, 5);
        repeat (2) @(posedge clk);
        #2;
        data_txn(1'b0, 64'h20, 64'd0, 4'd8, 1, 0);
        chk("store_readback", d_rdata, 64'h1234);
        repeat (2) @(posedge clk);
        #2;

        data_txn(1'b0, 64'h30, 64'd0, 4'd8, 0, 1);
        chk("wd_latency", last_d_lat, 17);
        chk("wd_rdata", d_rdata, 0);
        chk("wd_flag", timeout_err, 1);
        repeat (2) @(posedge clk);
        #2;

        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    data_txn(1'($urandom_range(0, 1)),
                             64'({$urandom_range(0, 511), 3'b000}),
                             {$urandom, $urandom},
                             sizes[$urandom_range(0, 3)],
                             $urandom_range(0, 4),
                             $urandom_range(0, 15) == 0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #2;
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    fetch_txn(64'h1000 + 64'({$urandom_range(0, 1023), 2'b00}),
                              $urandom_range(0, 4),
                              $urandom_range(0, 15) == 0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #2;
                end
            end
        join
        chk("sticky_timeout", timeout_err, 1);
        repeat (3) @(posedge clk);
        #2;

        q_d.push_back('{we: 1'b0, addr: 64'h40, wdata: '0, size: 4'd8,
                        exp: '0, k: 0, hang: 1'b1});
        d_we = 1'b0; d_addr = 64'h40; d_size = 4'd8;
        d_req = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_mem_req", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("mrst_mem_req", mem_req, 0);
        chk("mrst_mem_we", mem_we, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        chk("mrst_mem_wdata", mem_wdata, 0);
        chk("mrst_mem_size", mem_size, 0);
        chk("mrst_if_ready", if_ready, 0);
        chk("mrst_d_ready", d_ready, 0);
        chk("mrst_if_instr", 64'(if_instr), 0);
        chk("mrst_d_rdata", d_rdata, 0);
        chk("mrst_timeout", timeout_err, 0);
        d_req = 1'b0;
        q_d.delete();
        q_i.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        fetch_txn(64'h1008, 1, 0);
        chk("post_rst_latency", last_i_lat, 3);
        repeat (3) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
